lsu_mem_master: RTL

Load/store initiator that sits between the single-cycle core's memory stage and `data_memory`. It drives the `data_memory` port (WE, A, WD, RD).
- Converts RISC-V byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-indexed memory cycles.
- Sub-word stores use read-modify-write, because `data_memory` has no byte enables.
- Word-crossing misaligned accesses are split into two word accesses.
- The core side uses a simple REQ/BUSY/DONE handshake.

---
 rtl/lsu_mem_master_pkg.sv | 42 ++++
 rtl/lsu_mem_master_if.sv | 26 ++
 rtl/lsu_lane.sv | 48 ++++
 rtl/lsu_mem_master.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/lsu_mem_master_pkg.sv
// Shared encodings for the load/store initiator: FUNCT3 codes, FSM states,
// the latched request record and width/legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_WR0, S_WR1, S_DONE
  } state_t;

  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [29:0] w0;
    logic [1:0]  off;
    logic [2:0]  size;
    logic        split;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Unsigned widths exist only for loads.
  function automatic logic f3_legal(input logic write, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !write;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Core-side REQ/BUSY/DONE handshake plus the data_memory port, bundled.
interface lsu_mem_master_if #(parameter int MEM_AW = 32);
  logic              REQ;
  logic              WRITE;
  logic [2:0]        FUNCT3;
  logic [31:0]       ADDR;
  logic [31:0]       WDATA;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic [31:0]       RDATA;
  logic              MEM_WE;
  logic [MEM_AW-1:0] MEM_A;
  logic [31:0]       MEM_WD;
  logic [31:0]       MEM_RD;

  modport master (
    input  REQ, WRITE, FUNCT3, ADDR, WDATA, MEM_RD,
    output BUSY, DONE, ERR, RDATA, MEM_WE, MEM_A, MEM_WD
  );

  modport slave (
    output REQ, WRITE, FUNCT3, ADDR, WDATA, MEM_RD,
    input  BUSY, DONE, ERR, RDATA, MEM_WE, MEM_A, MEM_WD
  );
endinterface

// File: rtl/lsu_lane.sv
// Combinational byte-lane datapath: store merge into one word of the 8-byte
// window {w1,w0}, and load extract with sign/zero extension.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] bufw,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic        wsel,
  input  logic [2:0]  funct3,
  input  logic [31:0] ld_lo,
  input  logic [31:0] ld_hi,
  output logic [31:0] merged,
  output logic [31:0] ldata
);

  logic [31:0] win;
  logic [2:0]  lo, hi;

  assign lo = {1'b0, off};
  assign hi = lo + size;

  // g is the byte's position in the 8-byte window; it is replaced when it falls in [off, off+size).
  for (genvar j = 0; j < 4; j++) begin : g_byte
    logic [2:0] g;
    logic [1:0] k;
    logic       hit;
    assign g   = {wsel, 2'(j)};
    assign k   = g[1:0] - off;
    assign hit = (g >= lo) && (g < hi);
    assign merged[j*8 +: 8] = hit ? wdata[{k, 3'b000} +: 8] : bufw[j*8 +: 8];
  end

  assign win = 32'({ld_hi, ld_lo} >> {off, 3'b000});

  always_comb begin
    ldata = win;
    case (funct3)
      F3_B:    ldata = {{24{win[7]}}, win[7:0]};
      F3_H:    ldata = {{16{win[15]}}, win[15:0]};
      F3_BU:   ldata = {24'h0, win[7:0]};
      F3_HU:   ldata = {16'h0, win[15:0]};
      default: ldata = win;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: turns byte-addressed RISC-V accesses into word cycles
// on data_memory, with read-modify-write for sub-word stores and word splitting.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 32
) (
  input logic                CLK,
  input logic                RST_N,
  lsu_mem_master_if.master   bus
);

  state_t            state;
  req_t              rq;
  logic [31:0]       buf0, buf1, rdata;
  logic              busy, done, err, mem_we;
  logic [MEM_AW-1:0] mem_a;
  logic [29:0]       w1;
  logic [2:0]        a_size;
  logic              a_split, a_legal, a_swa;
  logic              wsel;
  logic [31:0]       lane_buf, ld_lo, ld_hi, merged, ldata;

  assign a_size  = size_of(bus.FUNCT3);
  assign a_split = ({1'b0, bus.ADDR[1:0]} + a_size) > 3'd4;
  assign a_legal = f3_legal(bus.WRITE, bus.FUNCT3);
  assign a_swa   = bus.WRITE && (bus.FUNCT3 == F3_W) && (bus.ADDR[1:0] == 2'b00);
  assign w1      = rq.w0 + 30'd1;

  // Loads finalize on the edge leaving RD0/RD1, so the word being read comes straight from MEM_RD.
  assign wsel     = (state == S_WR1);
  assign lane_buf = wsel ? buf1 : buf0;
  assign ld_lo    = (state == S_RD0) ? bus.MEM_RD : buf0;
  assign ld_hi    = (state == S_RD1) ? bus.MEM_RD : buf1;

  lsu_lane u_lane (
    .bufw   (lane_buf),
    .wdata  (rq.wdata),
    .off    (rq.off),
    .size   (rq.size),
    .wsel   (wsel),
    .funct3 (rq.funct3),
    .ld_lo  (ld_lo),
    .ld_hi  (ld_hi),
    .merged (merged),
    .ldata  (ldata)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      rq     <= '0;
      buf0   <= '0;
      buf1   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
      mem_we <= 1'b0;
      mem_a  <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.REQ) begin
          rq.write  <= bus.WRITE;
          rq.funct3 <= bus.FUNCT3;
          rq.w0     <= bus.ADDR[31:2];
          rq.off    <= bus.ADDR[1:0];
          rq.size   <= a_size;
          rq.split  <= a_split;
          rq.wdata  <= bus.WDATA;
          busy      <= 1'b1;
          err       <= 1'b0;
          if (!a_legal) begin
            state <= S_DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (a_swa) begin
            state  <= S_WR0;
            mem_we <= 1'b1;
            mem_a  <= MEM_AW'(bus.ADDR[31:2]);
          end else begin
            state <= S_RD0;
            mem_a <= MEM_AW'(bus.ADDR[31:2]);
          end
        end
        S_RD0: begin
          buf0 <= bus.MEM_RD;
          if (rq.write) begin
            state  <= S_WR0;
            mem_we <= 1'b1;
          end else if (rq.split) begin
            state <= S_RD1;
            mem_a <= MEM_AW'(w1);
          end else begin
            state <= S_DONE;
            rdata <= ldata;
            done  <= 1'b1;
          end
        end
        S_WR0: begin
          mem_we <= 1'b0;
          if (rq.split) begin
            state <= S_RD1;
            mem_a <= MEM_AW'(w1);
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_RD1: begin
          buf1 <= bus.MEM_RD;
          if (rq.write) begin
            state  <= S_WR1;
            mem_we <= 1'b1;
          end else begin
            state <= S_DONE;
            rdata <= ldata;
            done  <= 1'b1;
          end
        end
        S_WR1: begin
          mem_we <= 1'b0;
          state  <= S_DONE;
          done   <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.BUSY   = busy;
  assign bus.DONE   = done;
  assign bus.ERR    = err;
  assign bus.RDATA  = rdata;
  assign bus.MEM_WE = mem_we;
  assign bus.MEM_A  = mem_a;
  assign bus.MEM_WD = mem_we ? merged : 32'h0;

endmodule
